// File: rtl/ysyx_25080222_perf_pkg.sv
// ysyx_25080222_perf_pkg
// Shared constants for the performance-counter bank:
//   - counter index map (PERF_CYCLES .. PERF_IC_MISS), NUM_CTR, PERF_OVF_IDX
//   - latency tracker state encoding
package ysyx_25080222_perf_pkg;

  localparam logic [3:0] PERF_CYCLES    = 4'd0;
  localparam logic [3:0] PERF_IFU_FETCH = 4'd1;
  localparam logic [3:0] PERF_IFU_LAT   = 4'd2;
  localparam logic [3:0] PERF_LSU_LOAD  = 4'd3;
  localparam logic [3:0] PERF_LSU_STORE = 4'd4;
  localparam logic [3:0] PERF_LSU_LAT   = 4'd5;
  localparam logic [3:0] PERF_ALU       = 4'd6;
  localparam logic [3:0] PERF_CSR       = 4'd7;
  localparam logic [3:0] PERF_IC_HIT    = 4'd8;
  localparam logic [3:0] PERF_IC_MISS   = 4'd9;

  localparam int unsigned NUM_CTR = 10;

  // Index that exposes the overflow vector when the overflow feature is built in.
  localparam logic [3:0] PERF_OVF_IDX = 4'd15;

  typedef enum logic {
    LAT_IDLE = 1'b0,
    LAT_BUSY = 1'b1
  } lat_state_e;

endpackage

// File: rtl/ysyx_25080222_perf_lat_tracker.sv
// ysyx_25080222_perf_lat_tracker
// Tracks one outstanding request and emits a per-cycle latency increment
// while the request is in flight.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start, done   request issue / completion pulses
//   freeze        suppress latency increments (counting frozen)
//   clr           return to IDLE
//   busy          request outstanding
//   lat_inc       add one latency cycle this cycle
//   err           start seen while a request is already outstanding
//
// state    | meaning
// LAT_IDLE | no request outstanding
// LAT_BUSY | request issued, waiting for done; every cycle adds latency
module ysyx_25080222_perf_lat_tracker
  import ysyx_25080222_perf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic done,
  input  logic freeze,
  input  logic clr,
  output logic busy,
  output logic lat_inc,
  output logic err
);

  lat_state_e r_state;
  lat_state_e w_state_nxt;

  always_ff @(posedge clk) begin
    if (rst || clr) r_state <= LAT_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    lat_inc     = 1'b0;
    err         = 1'b0;
    case (r_state)
      LAT_IDLE: begin
        // start and done together completes immediately with zero latency
        if (start && !done) w_state_nxt = LAT_BUSY;
      end
      LAT_BUSY: begin
        busy    = 1'b1;
        lat_inc = !freeze;
        err     = start && !done;
        // done with a new start is a back-to-back request: stay BUSY
        if (done && !start) w_state_nxt = LAT_IDLE;
      end
      default: w_state_nxt = LAT_IDLE;
    endcase
  end

endmodule

// File: rtl/ysyx_25080222_perf_ctr.sv
// ysyx_25080222_perf_ctr
// Synthesizable performance-counter bank fed by the core's event pulses.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ifu_start/ifu_done            IFU fetch issue / return
//   lsu_start/lsu_rdone/lsu_wdone LSU issue / read return / write response
//   alu_retire, csr_retire        retire events
//   ic_hit, ic_miss               icache lookup result
//   halt                          ebreak: freezes all counting until rst/clr
//   clr                           clear counters, flags and trackers
//   rd_req/rd_idx                 read request (always accepted)
//   rd_valid/rd_data/rd_err       read response, one cycle after request
//   proto_err                     sticky: start seen while a tracker busy
//   frozen                        counting frozen by halt
// Build option: PERF_OVERFLOW_FLAG_EN adds a sticky per-counter wrap flag,
// readable as a vector at index 15.
module ysyx_25080222_perf_ctr
  import ysyx_25080222_perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_start,
  input  logic             ifu_done,
  input  logic             lsu_start,
  input  logic             lsu_rdone,
  input  logic             lsu_wdone,
  input  logic             alu_retire,
  input  logic             csr_retire,
  input  logic             ic_hit,
  input  logic             ic_miss,
  input  logic             halt,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [3:0]       rd_idx,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_err,
  output logic             proto_err,
  output logic             frozen
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [3:0]       LAST_IDX = 4'(NUM_CTR - 1);

  logic [CNT_W-1:0]   r_cnt [NUM_CTR];
  logic               r_frozen;
  logic               r_proto_err;
  logic               r_rd_valid;
  logic [CNT_W-1:0]   r_rd_data;
  logic               r_rd_err;

  logic [NUM_CTR-1:0] w_evt;
  logic [CNT_W-1:0]   w_rd_data;
  logic               w_rd_err;
  logic               w_lsu_done;
  logic               w_ifu_busy, w_ifu_lat_inc, w_ifu_err;
  logic               w_lsu_busy, w_lsu_lat_inc, w_lsu_err;

  assign w_lsu_done = lsu_rdone | lsu_wdone;

  ysyx_25080222_perf_lat_tracker u_ifu_trk (
    .clk     (clk),
    .rst     (rst),
    .start   (ifu_start),
    .done    (ifu_done),
    .freeze  (r_frozen),
    .clr     (clr),
    .busy    (w_ifu_busy),
    .lat_inc (w_ifu_lat_inc),
    .err     (w_ifu_err)
  );

  ysyx_25080222_perf_lat_tracker u_lsu_trk (
    .clk     (clk),
    .rst     (rst),
    .start   (lsu_start),
    .done    (w_lsu_done),
    .freeze  (r_frozen),
    .clr     (clr),
    .busy    (w_lsu_busy),
    .lat_inc (w_lsu_lat_inc),
    .err     (w_lsu_err)
  );

  always_comb begin
    w_evt                 = '0;
    w_evt[PERF_CYCLES]    = 1'b1;
    w_evt[PERF_IFU_FETCH] = ifu_done;
    w_evt[PERF_IFU_LAT]   = w_ifu_busy & w_ifu_lat_inc;
    w_evt[PERF_LSU_LOAD]  = lsu_rdone;
    w_evt[PERF_LSU_STORE] = lsu_wdone;
    w_evt[PERF_LSU_LAT]   = w_lsu_busy & w_lsu_lat_inc;
    w_evt[PERF_ALU]       = alu_retire;
    w_evt[PERF_CSR]       = csr_retire;
    w_evt[PERF_IC_HIT]    = ic_hit;
    w_evt[PERF_IC_MISS]   = ic_miss;
  end

`ifdef PERF_OVERFLOW_FLAG_EN
  logic               r_ovf [NUM_CTR];
  logic [NUM_CTR-1:0] w_ovf_vec;

  always_comb begin
    w_ovf_vec = '0;
    for (int i = 0; i < int'(NUM_CTR); i++) w_ovf_vec[i] = r_ovf[i];
  end
`endif

  for (genvar g = 0; g < int'(NUM_CTR); g++) begin : g_ctr
    always_ff @(posedge clk) begin
      if (rst || clr)                r_cnt[g] <= '0;
      else if (w_evt[g] && !r_frozen) r_cnt[g] <= r_cnt[g] + ONE;
    end
`ifdef PERF_OVERFLOW_FLAG_EN
    // Set on the increment that takes the counter from all-ones to zero.
    always_ff @(posedge clk) begin
      if (rst || clr)                                       r_ovf[g] <= 1'b0;
      else if (w_evt[g] && !r_frozen && (r_cnt[g] == '1)) r_ovf[g] <= 1'b1;
    end
`endif
  end

  // The halt cycle itself still counts because r_frozen rises only afterwards.
  always_ff @(posedge clk) begin
    if (rst || clr) r_frozen <= 1'b0;
    else if (halt)  r_frozen <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr)                  r_proto_err <= 1'b0;
    else if (w_ifu_err || w_lsu_err) r_proto_err <= 1'b1;
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b1;
    if (rd_idx <= LAST_IDX) begin
      w_rd_data = r_cnt[rd_idx];
      w_rd_err  = 1'b0;
    end
`ifdef PERF_OVERFLOW_FLAG_EN
    else if (rd_idx == PERF_OVF_IDX) begin
      w_rd_data[NUM_CTR-1:0] = w_ovf_vec;
      w_rd_err               = 1'b0;
    end
`endif
  end

  // Sampling the pre-update counter value makes a read coincident with clr
  // return the pre-clear value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_rd_data;
        r_rd_err  <= w_rd_err;
      end
    end
  end

  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_err    = r_rd_err;
  assign proto_err = r_proto_err;
  assign frozen    = r_frozen;

endmodule

// File: tb/tb_ysyx_25080222_perf_ctr.sv
`timescale 1ns/1ps
module tb_ysyx_25080222_perf_ctr;
  import ysyx_25080222_perf_pkg::*;

`ifdef PERF_OVERFLOW_FLAG_EN
  localparam int W   = 16;
  localparam bit OVF = 1'b1;
`else
  localparam int W   = 32;
  localparam bit OVF = 1'b0;
`endif

  localparam logic [10:0] NONE   = 11'h000;
  localparam logic [10:0] B_IS   = 11'h001;
  localparam logic [10:0] B_ID   = 11'h002;
  localparam logic [10:0] B_LS   = 11'h004;
  localparam logic [10:0] B_LR   = 11'h008;
  localparam logic [10:0] B_LW   = 11'h010;
  localparam logic [10:0] B_ALU  = 11'h020;
  localparam logic [10:0] B_CSR  = 11'h040;
  localparam logic [10:0] B_HIT  = 11'h080;
  localparam logic [10:0] B_MISS = 11'h100;
  localparam logic [10:0] B_HALT = 11'h200;
  localparam logic [10:0] B_CLR  = 11'h400;

  typedef struct {
    logic [10:0] ev;
    int          rep;
    logic        rd;
    logic [3:0]  idx;
    logic        chk;
    logic [63:0] exp;
    logic [63:0] mask;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
    logic         chk;
    logic [63:0]  cexp;
    logic [63:0]  mask;
    logic         cerr;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ifu_start = 0, ifu_done = 0, lsu_start = 0, lsu_rdone = 0, lsu_wdone = 0;
  logic         alu_retire = 0, csr_retire = 0, ic_hit = 0, ic_miss = 0, halt = 0, clr = 0;
  logic         rd_req = 0;
  logic [3:0]   rd_idx = '0;
  logic         rd_valid, rd_err, proto_err, frozen;
  logic [W-1:0] rd_data;

  always #5 clk = ~clk;

  ysyx_25080222_perf_ctr #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .ifu_start(ifu_start), .ifu_done(ifu_done),
    .lsu_start(lsu_start), .lsu_rdone(lsu_rdone), .lsu_wdone(lsu_wdone),
    .alu_retire(alu_retire), .csr_retire(csr_retire),
    .ic_hit(ic_hit), .ic_miss(ic_miss), .halt(halt), .clr(clr),
    .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .proto_err(proto_err), .frozen(frozen)
  );

  int n_pass = 0;
  int n_tot  = 0;

  vec_t  vt[$];
  resp_t sbq[$];

  // reference model state
  logic [W-1:0] m_cnt [10];
  logic [9:0]   m_ovf;
  logic         m_frz, m_perr, m_ib, m_lb;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
  endtask

  function automatic vec_t mk(input logic [10:0] e, input int rep, input logic rd,
                              input logic [3:0] idx, input logic chk, input logic [63:0] exp,
                              input logic [63:0] mask, input logic eerr);
    vec_t v;
    v.ev = e; v.rep = rep; v.rd = rd; v.idx = idx;
    v.chk = chk; v.exp = exp; v.mask = mask; v.eerr = eerr;
    return v;
  endfunction

  function automatic vec_t ev(input logic [10:0] e, input int rep);
    return mk(e, rep, 1'b0, 4'd0, 1'b0, 64'd0, 64'd0, 1'b0);
  endfunction

  function automatic vec_t rq(input logic [10:0] e, input logic [3:0] idx);
    return mk(e, 1, 1'b1, idx, 1'b0, 64'd0, 64'd0, 1'b0);
  endfunction

  function automatic vec_t rc(input logic [10:0] e, input logic [3:0] idx,
                              input logic [63:0] exp, input logic eerr);
    return mk(e, 1, 1'b1, idx, 1'b1, exp, '1, eerr);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 10; i++) m_cnt[i] = '0;
    m_ovf = '0; m_frz = 0; m_perr = 0; m_ib = 0; m_lb = 0;
  endtask

  task automatic model_step(input logic [10:0] e);
    logic [9:0] inc;
    logic       ld;
    ld  = e[3] | e[4];
    inc = {e[8], e[7], e[6], e[5], m_lb, e[4], e[3], m_ib, e[1], 1'b1};
    if (e[10]) begin
      model_clear();
    end else begin
      if (!m_frz)
        for (int i = 0; i < 10; i++)
          if (inc[i]) begin
            m_cnt[i] = m_cnt[i] + W'(1);
            if (m_cnt[i] == '0) m_ovf[i] = 1'b1;
          end
      if ((m_ib && e[0] && !e[1]) || (m_lb && e[2] && !ld)) m_perr = 1'b1;
      m_ib = m_ib ? !(e[1] && !e[0]) : (e[0] && !e[1]);
      m_lb = m_lb ? !(ld && !e[2])   : (e[2] && !ld);
      if (e[9]) m_frz = 1'b1;
    end
  endtask

  task automatic check_after_edge();
    resp_t p;
    if (sbq.size() > 0) begin
      p = sbq.pop_front();
      cmp("rd_valid", 64'(rd_valid), 64'd1);
      cmp("rd_data_model", 64'(rd_data), 64'(p.d));
      cmp("rd_err_model", 64'(rd_err), 64'(p.e));
      if (p.chk) begin
        cmp("rd_data_const", 64'(rd_data) & p.mask, p.cexp);
        cmp("rd_err_const", 64'(rd_err), 64'(p.cerr));
      end
    end else begin
      cmp("rd_valid_idle", 64'(rd_valid), 64'd0);
    end
    cmp("frozen", 64'(frozen), 64'(m_frz));
    cmp("proto_err", 64'(proto_err), 64'(m_perr));
  endtask

  task automatic apply(input vec_t v);
    resp_t p;
    for (int r = 0; r < v.rep; r++) begin
      {clr, halt, ic_miss, ic_hit, csr_retire, alu_retire,
       lsu_wdone, lsu_rdone, lsu_start, ifu_done, ifu_start} = v.ev;
      rd_req = v.rd && (r == v.rep - 1);
      rd_idx = v.idx;
      if (rd_req) begin
        p.chk = v.chk; p.cexp = v.exp; p.mask = v.mask; p.cerr = v.eerr;
        if (v.idx <= 4'd9) begin
          p.d = m_cnt[int'(v.idx)]; p.e = 1'b0;
        end else if (OVF && v.idx == 4'd15) begin
          p.d = W'(m_ovf); p.e = 1'b0;
        end else begin
          p.d = '0; p.e = 1'b1;
        end
        sbq.push_back(p);
      end
      model_step(v.ev);
      @(posedge clk);
      #1;
      check_after_edge();
    end
  endtask

  initial begin
    model_clear();

    // idle cycles then read the cycle counter
    vt.push_back(ev(NONE, 5));
    vt.push_back(rc(NONE, 0, 5, 0));
    // IFU: start, done 4 cycles later -> latency 4; then start+done together
    vt.push_back(ev(B_IS, 1));
    vt.push_back(ev(NONE, 3));
    vt.push_back(ev(B_ID, 1));
    vt.push_back(rc(NONE, 1, 1, 0));
    vt.push_back(rc(NONE, 2, 4, 0));
    vt.push_back(ev(B_IS | B_ID, 1));
    vt.push_back(rc(NONE, 1, 2, 0));
    vt.push_back(rc(NONE, 2, 4, 0));
    // LSU: load latency 3, store latency 2, then a protocol error
    vt.push_back(ev(B_LS, 1));
    vt.push_back(ev(NONE, 2));
    vt.push_back(ev(B_LR, 1));
    vt.push_back(ev(B_LS, 1));
    vt.push_back(ev(NONE, 1));
    vt.push_back(ev(B_LW, 1));
    vt.push_back(ev(B_LS, 1));
    vt.push_back(rc(B_LS, 5, 5, 0));
    vt.push_back(rc(NONE, 3, 1, 0));
    vt.push_back(rc(NONE, 4, 1, 0));
    // back-to-back done+start keeps the tracker busy
    vt.push_back(ev(B_LS | B_LW, 1));
    vt.push_back(ev(B_LR, 1));
    vt.push_back(rc(NONE, 3, 2, 0));
    vt.push_back(rc(NONE, 4, 2, 0));
    vt.push_back(rc(NONE, 5, 10, 0));
    // retire counts and halt freeze
    vt.push_back(ev(B_ALU, 3));
    vt.push_back(ev(B_CSR, 2));
    vt.push_back(ev(B_HALT, 1));
    vt.push_back(ev(B_ALU, 4));
    vt.push_back(rc(NONE, 6, 3, 0));
    vt.push_back(rc(NONE, 7, 2, 0));
    vt.push_back(rq(NONE, 0));
    vt.push_back(rq(NONE, 0));
    vt.push_back(ev(B_IS, 1));
    vt.push_back(rq(NONE, 2));
    vt.push_back(ev(B_CLR, 1));
    vt.push_back(rq(NONE, 0));
    for (int i = 1; i < 10; i++) vt.push_back(rc(NONE, 4'(i), 0, 0));
    // out-of-range indices
    vt.push_back(rc(NONE, 12, 0, 1));
    vt.push_back(rq(NONE, 10));
    vt.push_back(rq(NONE, 14));
    vt.push_back(rq(NONE, 15));
    // clr beats halt; read coincident with clr returns pre-clear value
    vt.push_back(ev(B_HALT | B_CLR, 1));
    vt.push_back(ev(B_MISS, 7));
    vt.push_back(rc(B_CLR | B_MISS, 9, 7, 0));
    vt.push_back(rc(NONE, 9, 0, 0));
`ifdef PERF_OVERFLOW_FLAG_EN
    vt.push_back(ev(B_HIT, 65536));
    vt.push_back(rc(NONE, 8, 0, 0));
    vt.push_back(mk(NONE, 1, 1'b1, 4'd15, 1'b1, 64'h100, 64'h100, 1'b0));
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_rd_valid", 64'(rd_valid), 64'd0);
    cmp("reset_rd_data", 64'(rd_data), 64'd0);
    cmp("reset_rd_err", 64'(rd_err), 64'd0);
    cmp("reset_proto_err", 64'(proto_err), 64'd0);
    cmp("reset_frozen", 64'(frozen), 64'd0);
    rst = 1'b0;

    foreach (vt[k]) apply(vt[k]);
    apply(ev(NONE, 2));
    cmp("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ysyx_25080222_perf_ctr.md
Name: ysyx_25080222_perf_ctr

Overview:
In-hardware performance-counter bank. It consumes the same event pulses that the simulation trace/DPI hooks observe (IFU fetch, LSU load/store, ALU/CSR retire, icache hit/miss, ebreak) and accumulates them in synthesizable counters. Fetch and LSU latency are tracked by small FSMs. A one-cycle-latency read port and a clear command let software or a debug bench inspect the counters without DPI.

Parameters:
CNT_W, 32, width of every counter and of rd_data; legal range 16..64.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_start  in  1  IFU AR handshake pulse (fetch issued)
ifu_done  in  1  IFU R handshake pulse (instruction returned)
lsu_start  in  1  LSU request issued (load or store)
lsu_rdone  in  1  LSU read data returned
lsu_wdone  in  1  LSU write response returned
alu_retire  in  1  ALU-class instruction retired
csr_retire  in  1  CSR-class instruction retired
ic_hit  in  1  icache lookup hit
ic_miss  in  1  icache lookup miss (SDRAM refill)
halt  in  1  ebreak retired; freezes counting
clr  in  1  clear all counters and flags
rd_req  in  1  read request; always accepted
rd_idx  in  4  counter index
rd_valid  out  1  read response valid
rd_data  out  CNT_W  counter value
rd_err  out  1  rd_idx out of range (with rd_valid)
proto_err  out  1  sticky: start seen while tracker busy
frozen  out  1  counting frozen by halt

Behaviour:
- Reset (rst=1): all counters 0; rd_valid, rd_data, rd_err, proto_err and frozen are 0; both trackers IDLE.
- Counter map: 0 cycles, 1 ifu_fetches, 2 ifu_lat_cycles, 3 lsu_loads, 4 lsu_stores, 5 lsu_lat_cycles, 6 alu_insts, 7 csr_insts, 8 ic_hits, 9 ic_misses. Indices 10..15 are out of range.
- Every counter increments by 1 in any cycle where its event is high, frozen=0, clr=0. Counters wrap modulo 2^CNT_W.
- cycles increments every cycle while not frozen.
- halt=1: frozen<=1 from the next cycle. The halt cycle itself still counts. frozen stays 1 until rst or clr.
- clr=1: all counters, proto_err and frozen <=0 next cycle. clr beats any same-cycle event or halt. Trackers return to IDLE.
- Latency tracker (one for IFU, one for LSU; LSU done = lsu_rdone|lsu_wdone):
  - IDLE, start -> BUSY.
  - BUSY: lat counter +1 every cycle (when not frozen).
  - BUSY, done & !start -> IDLE.
  - BUSY, done & start -> stay BUSY (back-to-back request).
  - BUSY, start & !done -> stay BUSY; proto_err<=1.
  - IDLE, done -> no state change; completion still counted, no latency added.
  - IDLE, start & done same cycle -> stay IDLE, latency 0.
  - Resulting latency of a start at cycle t with done at cycle t+k is k cycles.
- Completion counters count done pulses: ifu_fetches += ifu_done; lsu_loads += lsu_rdone; lsu_stores += lsu_wdone.
- Read port, no backpressure:
  - rd_req at cycle t -> rd_valid=1 at t+1, with rd_data = counter value as sampled at the end of cycle t (it excludes any increment made in cycle t).
  - Out-of-range index: rd_data=0, rd_err=1.
  - rd_valid is a one-cycle pulse per request. Back-to-back requests give back-to-back responses.
- A read in the same cycle as clr returns the pre-clear value.

Optional Feature:
PERF_OVERFLOW_FLAG_EN
- Defined: a sticky overflow bit per counter, set when that counter wraps from all-ones to 0 and cleared by rst/clr.
  - Index 15 becomes readable and returns the overflow vector in bits [9:0] (upper bits 0, rd_err=0).
- Undefined: no overflow bits; index 15 is out of range like 10..14.

Decomposition:
- Package ysyx_25080222_perf_pkg holds:
  - index constants PERF_CYCLES..PERF_IC_MISS;
  - NUM_CTR=10;
  - PERF_OVF_IDX=15;
  - the tracker state enum {LAT_IDLE, LAT_BUSY}.
- One sub-module, ysyx_25080222_perf_lat_tracker: inputs start, done, freeze, clr; outputs busy, lat_inc, err. Instantiated twice.

Test Plan:
- Reset, then 5 idle cycles, rd_req idx 0 -> rd_valid next cycle, rd_data=5 (±1 per defined sampling), rd_err=0.
- ifu_start at t=10, ifu_done at t=14, then read idx 1 and 2 -> 1 and 4. Then a start at t=20 with done at t=20 -> idx1=2, idx2 still 4.
- lsu_start, 3 cycles later lsu_rdone; lsu_start, 2 cycles later lsu_wdone; then a second lsu_start while BUSY -> idx3=1, idx4=1, idx5=5, proto_err=1.
- 3 alu_retire, 2 csr_retire, then halt, then 4 more alu_retire -> idx6=3, idx7=2, frozen=1, cycles stops advancing. clr -> all reads 0, frozen=0.
- rd_idx=12 -> rd_data=0, rd_err=1. With PERF_OVERFLOW_FLAG_EN and CNT_W=16: 65536 ic_hit pulses -> idx8=0, idx15 bit8=1.
- clr asserted in the same cycle as ic_miss and rd_req idx9 (value 7) -> response 7, next read 0.
